aes_round_ctrl: RTL and testbench

- Round sequencer for the AES-128 datapath. Accepts one 128-bit block and steps it through three external stages: the substitution stage (SubBytes+ShiftRows), the mix-columns stage and the add-round-key stage. Each stage uses a one-cycle ready/done pulse handshake.
- Owns the round counter, the round-key index, stage ordering for encrypt and decrypt, and a per-stage watchdog.
- Sits between the block input framing logic and the key schedule RAM.

---
 rtl/aes_round_ctrl_if.sv | 39 +++
 rtl/aes_round_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : aes_round_ctrl_if
// Purpose   : Stage-side bus between the AES round sequencer and the external
//             substitution, mix-columns and add-round-key stages. Each stage
//             has a one-cycle ready (start) pulse and a one-cycle done pulse.
// Revision  : 1.0  initial release
// ============================================================================
interface aes_round_ctrl_if;
  logic         encry;
  logic [3:0]   rk_idx;
  logic         sub_ready;
  logic [127:0] sub_in;
  logic         sub_done;
  logic [127:0] sub_out;
  logic         mix_ready;
  logic [127:0] mix_in;
  logic         mix_done;
  logic [127:0] mix_out;
  logic         ark_ready;
  logic [127:0] ark_in;
  logic         ark_done;
  logic [127:0] ark_out;

  // Sequencer side
  modport master (
    output encry, rk_idx,
    output sub_ready, sub_in, mix_ready, mix_in, ark_ready, ark_in,
    input  sub_done, sub_out, mix_done, mix_out, ark_done, ark_out
  );

  // Stage side
  modport slave (
    input  encry, rk_idx,
    input  sub_ready, sub_in, mix_ready, mix_in, ark_ready, ark_in,
    output sub_done, sub_out, mix_done, mix_out, ark_done, ark_out
  );
endinterface
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_ctrl
// Purpose  : AES-128 round sequencer. Steps one 128-bit block through the
//            external SUB / MIX / ARK stages in encrypt or inverse-cipher
//            order, owns the round counter / round-key index and guards every
//            stage wait with a watchdog.
// Revision : 1.0  initial release
// ============================================================================
module aes_round_ctrl #(
  parameter int NR  = 10,
  parameter int TMO = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             encrypt_i,
  input  logic [127:0]     block_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [127:0]     block_out_o,
  aes_round_ctrl_if.master stg
);

  localparam logic [3:0] C_NR       = 4'(NR);
  localparam logic [7:0] C_WDG_LAST = 8'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_SUB = 2'd0,
    OP_MIX = 2'd1,
    OP_ARK = 2'd2
  } op_t;

  state_t       state_q;
  op_t          op_q, op_d;
  logic [3:0]   round_q, round_d;
  logic         last_d;
  logic [127:0] st_q;
  logic [127:0] block_out_q;
  logic         encry_q;
  logic         busy_q, done_q, error_q;
  logic         sub_ready_q, mix_ready_q, ark_ready_q;
  logic [7:0]   wdg_q;
  logic         w_sel_done;
  logic [127:0] w_sel_out;

  // Select the done/result of the stage currently being waited on; a done in
  // the same cycle as its ready pulse is too early and is masked out.
  always_comb begin
    w_sel_done = 1'b0;
    w_sel_out  = stg.sub_out;
    case (op_q)
      OP_SUB: begin w_sel_done = stg.sub_done; w_sel_out = stg.sub_out; end
      OP_MIX: begin w_sel_done = stg.mix_done; w_sel_out = stg.mix_out; end
      OP_ARK: begin w_sel_done = stg.ark_done; w_sel_out = stg.ark_out; end
      default: ;
    endcase
    if (sub_ready_q | mix_ready_q | ark_ready_q) begin
      w_sel_done = 1'b0;
    end
  end

  // Next op / round after the current op completes. Encrypt runs
  // ARK(0), {SUB,MIX,ARK(r)} r=1..NR-1, SUB, ARK(NR); decrypt runs
  // ARK(NR), {SUB,ARK(r),MIX} r=NR-1..1, SUB, ARK(0).
  always_comb begin
    op_d    = op_q;
    round_d = round_q;
    last_d  = 1'b0;
    case (op_q)
      OP_ARK: begin
        if (encry_q) begin
          if (round_q == C_NR) begin
            last_d = 1'b1;
          end else begin
            round_d = round_q + 4'd1;
            op_d    = OP_SUB;
          end
        end else begin
          if (round_q == 4'd0) begin
            last_d = 1'b1;
          end else if (round_q == C_NR) begin
            round_d = round_q - 4'd1;
            op_d    = OP_SUB;
          end else begin
            op_d = OP_MIX;
          end
        end
      end
      OP_SUB: begin
        if (encry_q && (round_q != C_NR)) begin
          op_d = OP_MIX;
        end else begin
          op_d = OP_ARK;
        end
      end
      OP_MIX: begin
        if (encry_q) begin
          op_d = OP_ARK;
        end else begin
          round_d = round_q - 4'd1;
          op_d    = OP_SUB;
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ARK;
      round_q     <= 4'd0;
      st_q        <= '0;
      block_out_q <= '0;
      encry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      sub_ready_q <= 1'b0;
      mix_ready_q <= 1'b0;
      ark_ready_q <= 1'b0;
      wdg_q       <= 8'd0;
    end else begin
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      sub_ready_q <= 1'b0;
      mix_ready_q <= 1'b0;
      ark_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            st_q    <= block_in_i;
            encry_q <= encrypt_i;
            busy_q  <= 1'b1;
            op_q    <= OP_ARK;
            round_q <= encrypt_i ? 4'd0 : C_NR;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          sub_ready_q <= (op_q == OP_SUB);
          mix_ready_q <= (op_q == OP_MIX);
          ark_ready_q <= (op_q == OP_ARK);
          wdg_q       <= 8'd0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // A legal done takes priority over a watchdog expiring this cycle.
          if (w_sel_done) begin
            st_q    <= w_sel_out;
            op_q    <= op_d;
            round_q <= round_d;
            state_q <= last_d ? S_FIN : S_ISSUE;
          end else if (wdg_q == C_WDG_LAST) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            wdg_q <= wdg_q + 8'd1;
          end
        end
        S_FIN: begin
          block_out_q <= st_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign block_out_o   = block_out_q;
  assign stg.encry     = encry_q;
  assign stg.rk_idx    = round_q;
  assign stg.sub_ready = sub_ready_q;
  assign stg.mix_ready = mix_ready_q;
  assign stg.ark_ready = ark_ready_q;
  assign stg.sub_in    = st_q;
  assign stg.mix_in    = st_q;
  assign stg.ark_in    = st_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_ctrl
// Purpose  : Self-checking bench for aes_round_ctrl with behavioural AES
//            stage models (SubBytes/ShiftRows, MixColumns, AddRoundKey).
// Revision : 1.0  initial release
// ============================================================================
module tb_aes_round_ctrl;

  logic         clk;
  logic         reset;
  logic         start;
  logic         encrypt;
  logic [127:0] block_in;
  logic         busy, done, error;
  logic [127:0] block_out;

  aes_round_ctrl_if sif();

  aes_round_ctrl #(.NR(10), .TMO(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start),
    .encrypt_i   (encrypt),
    .block_in_i  (block_in),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .block_out_o (block_out),
    .stg         (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // AES reference pieces
  logic [7:0]   sbox [256];
  logic [7:0]   isbox[256];
  logic [127:0] rk   [11];

  bit rand_lat  = 0;
  bit spur_en   = 0;
  bit sub_stall = 0;

  // Monitor counters
  int n_done = 0, n_error = 0, n_sub = 0, n_mix = 0, n_ark = 0, n_mix_r10 = 0;
  int n_spur = 0;
  int cyc_ctr = 0, last_sub_cyc = 0, err_cyc = 0;
  logic [3:0] rk_log[$];

  typedef struct {
    logic         enc;
    logic [127:0] key;
    logic [127:0] din;
    logic [127:0] res;
    bit           rlat;
    bit           spur;
    bit           poke;
  } vec_t;

  vec_t vt[6];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h01;
      logic [7:0] s;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] f_sub(input logic [127:0] x, input logic enc);
    logic [7:0]   a[16];
    logic [7:0]   o[16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = x[127-8*i -: 8];
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++)
        if (enc) o[rr+4*c] = sbox[a[rr+4*((c+rr)%4)]];
        else     o[rr+4*((c+rr)%4)] = isbox[a[rr+4*c]];
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
    return r;
  endfunction

  function automatic logic [127:0] f_mix(input logic [127:0] x, input logic enc);
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      if (enc) r[127-32*c -: 32] = {
          gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3,
          a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3,
          a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03),
          gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02)};
      else r[127-32*c -: 32] = {
          gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
          gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
          gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
          gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
    end
    return r;
  endfunction

  // Substitution stage model (can be stalled to starve the watchdog)
  initial begin
    logic [127:0] s_res;
    int           s_lat;
    sif.sub_done = 1'b0;
    sif.sub_out  = '0;
    forever begin
      @(negedge clk);
      if (sif.sub_ready && !sub_stall) begin
        s_res = f_sub(sif.sub_in, sif.encry);
        s_lat = rand_lat ? int'($urandom_range(20, 1)) : 1;
        repeat (s_lat) @(negedge clk);
        sif.sub_done = 1'b1;
        sif.sub_out  = s_res;
        @(negedge clk);
        sif.sub_done = 1'b0;
      end
    end
  end

  // Mix stage model, also injects a spurious mix_done while SUB is pending
  initial begin
    logic [127:0] m_res;
    int           m_lat;
    sif.mix_done = 1'b0;
    sif.mix_out  = '0;
    forever begin
      @(negedge clk);
      if (sif.mix_ready) begin
        m_res = f_mix(sif.mix_in, sif.encry);
        m_lat = rand_lat ? int'($urandom_range(20, 1)) : 1;
        repeat (m_lat) @(negedge clk);
        sif.mix_done = 1'b1;
        sif.mix_out  = m_res;
        @(negedge clk);
        sif.mix_done = 1'b0;
      end else if (spur_en && sif.sub_ready) begin
        @(negedge clk);
        sif.mix_done = 1'b1;
        sif.mix_out  = {4{32'hdeadbeef}};
        n_spur++;
        @(negedge clk);
        sif.mix_done = 1'b0;
      end
    end
  end

  // Add-round-key stage model, logs the key index presented with each ready
  initial begin
    logic [127:0] k_res;
    int           k_lat;
    sif.ark_done = 1'b0;
    sif.ark_out  = '0;
    forever begin
      @(negedge clk);
      if (sif.ark_ready) begin
        rk_log.push_back(sif.rk_idx);
        k_res = sif.ark_in ^ rk[sif.rk_idx];
        k_lat = rand_lat ? int'($urandom_range(20, 1)) : 1;
        repeat (k_lat) @(negedge clk);
        sif.ark_done = 1'b1;
        sif.ark_out  = k_res;
        @(negedge clk);
        sif.ark_done = 1'b0;
      end
    end
  end

  // Event monitor
  always @(negedge clk) begin
    cyc_ctr++;
    if (done)  n_done++;
    if (error) begin n_error++; err_cyc = cyc_ctr; end
    if (sif.sub_ready) begin n_sub++; last_sub_cyc = cyc_ctr; end
    if (sif.mix_ready) begin
      n_mix++;
      if (sif.rk_idx == 4'd10) n_mix_r10++;
    end
    if (sif.ark_ready) n_ark++;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Launch one block from a negedge and wait (bounded) for done or error.
  task automatic run_block(input logic enc, input logic [127:0] din, input bit poke,
                           output bit timeout, output int gaps);
    int cyc = 0;
    gaps    = 0;
    timeout = 0;
    start    = 1'b1;
    encrypt  = enc;
    block_in = din;
    @(negedge clk);
    start = 1'b0;
    while (!done && !error) begin
      if (!busy) gaps++;
      if (cyc >= 2000) begin timeout = 1; break; end
      start = poke && (cyc == 10);
      if (start) begin encrypt = ~enc; block_in = ~din; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    bit   tmo;
    int   gaps;
    int   s_done, s_err, s_sub, s_mix, s_ark, s_r10, s_log;
    bit   found;
    logic [43:0] order;

    vt[0] = '{enc:1'b1, key:K1,   din:P1,   res:C1,   rlat:0, spur:0, poke:1};
    vt[1] = '{enc:1'b0, key:K1,   din:C1,   res:P1,   rlat:0, spur:0, poke:0};
    vt[2] = '{enc:1'b1, key:K2,   din:P2,   res:C2,   rlat:1, spur:1, poke:0};
    vt[3] = '{enc:1'b0, key:K2,   din:C2,   res:P2,   rlat:1, spur:1, poke:1};
    vt[4] = '{enc:1'b0, key:'0,   din:C0,   res:'0,   rlat:1, spur:0, poke:0};
    vt[5] = '{enc:1'b1, key:'0,   din:'0,   res:C0,   rlat:0, spur:1, poke:0};

    build_sbox();
    reset = 1'b1; start = 1'b0; encrypt = 1'b0; block_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 128'({busy, done, error, sif.sub_ready, sif.mix_ready, sif.ark_ready,
                          sif.encry, sif.rk_idx}), 128'd0);
    chk("reset_block_out", block_out, 128'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      expand(vt[v].key);
      rand_lat = vt[v].rlat;
      spur_en  = vt[v].spur;
      s_done = n_done; s_err = n_error; s_sub = n_sub; s_mix = n_mix; s_ark = n_ark;
      s_r10  = n_mix_r10; s_log = rk_log.size();
      run_block(vt[v].enc, vt[v].din, vt[v].poke, tmo, gaps);
      chk($sformatf("v%0d_timeout", v), 128'(tmo), 128'd0);
      chk($sformatf("v%0d_result", v), block_out, vt[v].res);
      chk($sformatf("v%0d_done_count", v), 128'(n_done - s_done), 128'd1);
      chk($sformatf("v%0d_error_count", v), 128'(n_error - s_err), 128'd0);
      chk($sformatf("v%0d_busy_gaps", v), 128'(gaps), 128'd0);
      if (vt[v].enc) begin
        chk($sformatf("v%0d_op_counts", v),
            128'({32'(n_sub - s_sub), 32'(n_mix - s_mix), 32'(n_ark - s_ark), 32'(n_mix_r10 - s_r10)}),
            128'({32'd10, 32'd9, 32'd11, 32'd0}));
      end else begin
        order = '1;
        if (rk_log.size() - s_log == 11) begin
          order = '0;
          for (int i = 0; i < 11; i++) order = {order[39:0], rk_log[s_log + i]};
        end
        chk($sformatf("v%0d_rk_order", v), 128'(order), 128'(44'ha9876543210));
      end
    end
    rand_lat = 0;
    spur_en  = 0;

    // Watchdog: stall the substitution stage
    sub_stall = 1;
    s_done = n_done; s_err = n_error;
    run_block(1'b1, P1, 1'b0, tmo, gaps);
    chk("wdg_timeout", 128'(tmo), 128'd0);
    chk("wdg_error_count", 128'(n_error - s_err), 128'd1);
    chk("wdg_done_count", 128'(n_done - s_done), 128'd0);
    chk("wdg_busy_after", 128'(busy), 128'd0);
    chk("wdg_block_out_held", block_out, C0);
    chk("wdg_wait_cycles", 128'(err_cyc - last_sub_cyc), 128'd255);
    sub_stall = 0;
    repeat (5) @(negedge clk);
    expand(K1);
    run_block(1'b1, P1, 1'b0, tmo, gaps);
    chk("wdg_restart_result", block_out, C1);

    // Reset in the middle of round 5
    s_done = n_done; s_err = n_error;
    start = 1'b1; encrypt = 1'b1; block_in = P2;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (sif.mix_ready && sif.rk_idx == 4'd5) found = 1;
    end
    chk("rst_reached_round5", 128'(found), 128'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctl", 128'({busy, done, error, sif.sub_ready, sif.mix_ready, sif.ark_ready,
                            sif.encry, sif.rk_idx}), 128'd0);
    chk("rst_mid_block_out", block_out, 128'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_silent", 128'({32'(n_done - s_done), 32'(n_error - s_err)}), 128'd0);
    run_block(1'b1, P1, 1'b1, tmo, gaps);
    chk("rst_fresh_result", block_out, C1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
